// File: rtl/bist_scan_ctrl.sv
// bist_scan_ctrl: LFSR scan/PI stimulus generator with MISR response compaction and golden compare
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start             begins a test when sampled high in IDLE
//   scan_out          serial response from the CUT scan chain
//   scan_in, scan_en  serial stimulus and shift enable to the CUT
//   pi_out            pseudo-random CUT functional inputs, held through capture
//   busy, done, pass  test in progress / finished / signature matched golden
//   signature         current MISR contents
module bist_scan_ctrl #(
   parameter int          CHAIN_LEN    = 12,
   parameter int          NUM_PATTERNS = 64,
   parameter int          PI_W         = 5,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            scan_out,
   output logic            scan_in,
   output logic            scan_en,
   output logic [PI_W-1:0] pi_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     signature
);
   localparam int BW = $clog2(CHAIN_LEN);
   localparam int PW = $clog2(NUM_PATTERNS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PATTERNS - 1);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SHIFT   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] FLUSH   = 3'd3;
   localparam logic [2:0] COMPARE = 3'd4;
   logic [2:0]    state;
   logic [15:0]   lfsr;
   logic [15:0]   misr;
   logic [BW-1:0] bit_cnt;
   logic [PW-1:0] pat_cnt;
   logic          fb;
   logic          misr_en;
   logic [15:0]   misr_nxt;
   assign fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign misr_nxt  = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h100B : 16'h0000) ^ {15'b0, scan_out};
   // the first load pass shifts out whatever the chain held before the test, so it is not compacted
   assign misr_en   = (state == SHIFT && pat_cnt != '0) || state == FLUSH;
   assign scan_in   = lfsr[15];
   assign scan_en   = state == SHIFT || state == FLUSH;
   assign busy      = state != IDLE;
   assign signature = misr;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         lfsr    <= LFSR_SEED;
         misr    <= '0;
         pi_out  <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
         bit_cnt <= '0;
         pat_cnt <= '0;
      end else begin
         if (misr_en) misr <= misr_nxt;
         case (state)
            IDLE: if (start) begin
               state   <= SHIFT;
               lfsr    <= LFSR_SEED;
               misr    <= '0;
               bit_cnt <= '0;
               pat_cnt <= '0;
               done    <= 1'b0;
               pass    <= 1'b0;
            end
            SHIFT: begin
               lfsr    <= {lfsr[14:0], fb};
               bit_cnt <= bit_cnt == LAST_BIT ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  pi_out <= lfsr[PI_W-1:0];
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               pat_cnt <= pat_cnt + 1'b1;
               bit_cnt <= '0;
               state   <= pat_cnt == LAST_PAT ? FLUSH : SHIFT;
            end
            FLUSH: begin
               bit_cnt <= bit_cnt == LAST_BIT ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) state <= COMPARE;
            end
            COMPARE: begin
               pass  <= misr == GOLDEN_SIG;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bist_scan_ctrl.sv
// tb_bist_scan_ctrl: randomized self-checking bench for bist_scan_ctrl with a loopback CUT model
module tb_bist_scan_ctrl;
   localparam int CL = 4;
   localparam int NP = 2;
   localparam int PW = 5;
   localparam int EXP_BUSY = NP * (CL + 1) + CL + 1;
   localparam logic [15:0] SEED = 16'hACE1;
   logic clock = 1'b0, reset = 1'b0, start = 1'b0, clk_en = 1'b0;
   logic scan_out, scan_in, scan_en, busy, done, pass;
   logic [PW-1:0] pi_out;
   logic [15:0] signature;
   int checks = 0, failures = 0;
   logic so_mode = 1'b0;
   logic [CL-1:0] chain = '0;
   int shift_idx = 0, flip_at = -1;
   logic [199:0] pulse_mask = '0;
   logic en_log [200];
   logic si_log [200];
   logic [PW-1:0] pi_log [200];

   bist_scan_ctrl #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .PI_W(PW), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) dut (
      .clock(clock), .reset(reset), .start(start), .scan_out(scan_out), .scan_in(scan_in), .scan_en(scan_en),
      .pi_out(pi_out), .busy(busy), .done(done), .pass(pass), .signature(signature));

   initial forever begin
      #5;
      if (clk_en) clock = ~clock;
   end

   // CUT: CL-flop chain, capture XORs every flop with pi_out[0]; optional single flipped response bit
   assign scan_out = so_mode & (chain[CL-1] ^ (shift_idx == flip_at));
   always @(posedge clock) begin
      if (start && !busy) shift_idx <= 0;
      else if (scan_en) shift_idx <= shift_idx + 1;
      if (scan_en) chain <= {chain[CL-2:0], scan_in};
      else if (busy) chain <= chain ^ {CL{pi_out[0]}};
   end

   function automatic logic [15:0] lfsr_at(input int k);
      logic [15:0] l;
      l = SEED;
      for (int n = 0; n < k; n++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      return l;
   endfunction

   // response stream: pattern p's loaded bits, each XORed with pi bit 0 of that pass, emitted in load order
   function automatic logic [15:0] ref_sig(input int flip);
      logic [15:0] m, ld, cap;
      logic b;
      m = '0;
      for (int j = 0; j < NP * CL; j++) begin
         ld  = lfsr_at(j);
         cap = lfsr_at((j / CL) * CL + CL - 1);
         b   = ld[15] ^ cap[0] ^ (j + CL == flip);
         m   = {m[14:0], 1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {15'b0, b};
      end
      return m;
   endfunction

   task automatic run_test(output int cyc);
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
         en_log[cyc] = scan_en;
         si_log[cyc] = scan_in;
         pi_log[cyc] = pi_out;
         start = pulse_mask[cyc];
         cyc++;
         @(negedge clock);
      end
      start = 1'b0;
      if (cyc >= 200) begin
         checks++;
         failures++;
         $display("FAIL timeout: busy still %b after %0d cycles", busy, cyc);
      end
   endtask

   task automatic test_reset;
      #3 reset = 1'b1;
      #1;
      checks++;
      if ({scan_en, busy, done, pass, pi_out, signature} !== 25'd0) begin
         failures++;
         $display("FAIL reset_async: scan_en=%b busy=%b done=%b pass=%b pi=%h sig=%h, want all 0", scan_en, busy, done, pass, pi_out, signature);
      end
      clk_en = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (scan_in !== 1'b1 || signature !== 16'h0) begin
         failures++;
         $display("FAIL reset_clocked: scan_in=%b sig=%h, want 1 0000", scan_in, signature);
      end
      reset = 1'b0;
   endtask

   task automatic test_sequencing;
      int cyc, p, w;
      logic [3:0] first4;
      logic [15:0] l;
      logic exp_en;
      first4 = 4'b1010;
      so_mode = 1'b0;
      run_test(cyc);
      checks++;
      if (cyc != EXP_BUSY) begin
         failures++;
         $display("FAIL busy_len: got %0d want %0d", cyc, EXP_BUSY);
      end
      for (int k = 0; k < EXP_BUSY; k++) begin
         p = k / (CL + 1);
         w = k % (CL + 1);
         exp_en = (k < NP * (CL + 1)) ? (w < CL) : (k < NP * (CL + 1) + CL);
         checks++;
         if (en_log[k] !== exp_en) begin
            failures++;
            $display("FAIL scan_en[%0d]: got %b want %b", k, en_log[k], exp_en);
         end
         if (k < 4) begin
            checks++;
            if (si_log[k] !== first4[3-k]) begin
               failures++;
               $display("FAIL scan_in_first[%0d]: got %b want %b", k, si_log[k], first4[3-k]);
            end
         end
         if (exp_en) begin
            l = lfsr_at(k < NP * (CL + 1) ? p * CL + w : NP * CL);
            checks++;
            if (si_log[k] !== l[15]) begin
               failures++;
               $display("FAIL scan_in[%0d]: got %b want %b", k, si_log[k], l[15]);
            end
         end else if (k < NP * (CL + 1)) begin
            l = lfsr_at(p * CL + CL - 1);
            checks++;
            if (pi_log[k] !== l[PW-1:0]) begin
               failures++;
               $display("FAIL pi_out[%0d]: got %h want %h", k, pi_log[k], l[PW-1:0]);
            end
         end
      end
   endtask

   task automatic test_stuck_at0;
      int cyc;
      so_mode = 1'b0;
      run_test(cyc);
      checks++;
      if (signature !== 16'h0 || done !== 1'b1 || pass !== 1'b1) begin
         failures++;
         $display("FAIL stuck0: sig=%h done=%b pass=%b want 0000 1 1", signature, done, pass);
      end
   endtask

   task automatic test_loopback;
      int cyc;
      logic [15:0] clean, e;
      so_mode = 1'b1;
      flip_at = -1;
      clean = ref_sig(-1);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      run_test(cyc);
      checks++;
      if (signature !== clean || pass !== (clean == 16'h0) || done !== 1'b1) begin
         failures++;
         $display("FAIL loopback: sig=%h pass=%b done=%b want %h %b 1", signature, pass, done, clean, clean == 16'h0);
      end
      for (int t = 0; t < 4; t++) begin
         flip_at = $urandom_range(CL, NP * CL + CL - 1);
         e = ref_sig(flip_at);
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_test(cyc);
         checks++;
         if (signature !== e || pass !== (e == 16'h0)) begin
            failures++;
            $display("FAIL loopback_flip@%0d: sig=%h pass=%b want %h %b", flip_at, signature, pass, e, e == 16'h0);
         end
         checks++;
         if (signature === clean) begin
            failures++;
            $display("FAIL flip_detect@%0d: sig=%h equals clean %h", flip_at, signature, clean);
         end
      end
      flip_at = -1;
   endtask

   task automatic test_busy_start;
      int cyc;
      logic [15:0] e;
      so_mode = 1'b1;
      e = ref_sig(-1);
      pulse_mask = '0;
      pulse_mask[$urandom_range(0, CL - 1)] = 1'b1;
      pulse_mask[$urandom_range(NP * (CL + 1), NP * (CL + 1) + CL - 1)] = 1'b1;
      pulse_mask[EXP_BUSY - 1] = 1'b1;
      run_test(cyc);
      pulse_mask = '0;
      checks++;
      if (cyc != EXP_BUSY || signature !== e) begin
         failures++;
         $display("FAIL busy_start: cycles=%0d sig=%h want %0d %h", cyc, signature, EXP_BUSY, e);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL start_on_compare: busy=%b done=%b want 0 1", busy, done);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      logic [15:0] e;
      so_mode = 1'b1;
      e = ref_sig(-1);
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      repeat (CL + 1 + 2) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({scan_en, busy, done, pass, pi_out, signature} !== 25'd0 || scan_in !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: scan_en=%b busy=%b done=%b pass=%b pi=%h sig=%h scan_in=%b", scan_en, busy, done, pass, pi_out, signature, scan_in);
      end
      @(negedge clock) reset = 1'b0;
      run_test(cyc);
      checks++;
      if (cyc != EXP_BUSY || signature !== e || done !== 1'b1) begin
         failures++;
         $display("FAIL rerun_after_reset: cycles=%0d sig=%h done=%b want %0d %h 1", cyc, signature, done, EXP_BUSY, e);
      end
   endtask

   initial begin
      test_reset;
      test_sequencing;
      test_stuck_at0;
      test_loopback;
      test_busy_start;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
